// File: rtl/instr_fetch_unit.sv
// ============================================================================
// instr_fetch_unit : RV64I fetch stage with 1-entry skid buffer and redirect
// Rev 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit #(
   parameter int               XLEN      = 64,
   parameter logic [XLEN-1:0]  RESET_PC  = '0,
   parameter logic [31:0]      NOP_INSTR = 32'h00000013
) (
   input  logic              clk,
   input  logic              rst,
   output logic              imem_req,
   output logic [XLEN-1:0]   imem_addr,
   input  logic              imem_ready,
   input  logic              imem_rvalid,
   input  logic [31:0]       imem_rdata,
   input  logic              branch_taken,
   input  logic [XLEN-1:0]   branch_target,
   input  logic              stall,
   output logic              instr_valid,
   output logic [31:0]       instr,
   output logic [XLEN-1:0]   pc
);

   localparam logic [XLEN-1:0] c_align_mask = ~XLEN'(3);
   localparam logic [XLEN-1:0] c_step       = XLEN'(4);
   localparam logic [XLEN-1:0] c_reset_pc   = RESET_PC & c_align_mask;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_REQ  = 2'd1,
      S_WAIT = 2'd2,
      S_HOLD = 2'd3
   } state_t;

   state_t            r_state;
   logic [XLEN-1:0]   r_fetch_pc;
   logic              r_kill;
   logic              r_skid_valid;
   logic [31:0]       r_skid_instr;
   logic [XLEN-1:0]   r_skid_pc;

   logic [XLEN-1:0]   w_target;
   logic [XLEN-1:0]   w_next_pc;

   assign w_target  = branch_target & c_align_mask;
   assign w_next_pc = r_fetch_pc + c_step;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_fetch_pc   <= c_reset_pc;
         r_kill       <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_instr <= NOP_INSTR;
         r_skid_pc    <= '0;
         imem_req     <= 1'b0;
         imem_addr    <= c_reset_pc;
         instr_valid  <= 1'b0;
         instr        <= NOP_INSTR;
         pc           <= '0;
      end else begin
         // Decode consumed the current word; a load below may overwrite this.
         if (instr_valid && !stall) begin
            instr_valid <= 1'b0;
            instr       <= NOP_INSTR;
         end

         if (branch_taken) begin
            instr_valid  <= 1'b0;
            instr        <= NOP_INSTR;
            r_skid_valid <= 1'b0;
            r_fetch_pc   <= w_target;
            case (r_state)
               S_WAIT: begin
                  if (imem_rvalid) begin
                     r_kill    <= 1'b0;
                     r_state   <= S_REQ;
                     imem_req  <= 1'b1;
                     imem_addr <= w_target;
                  end else begin
                     r_kill <= 1'b1;
                  end
               end
               S_REQ: begin
                  // A handshake in this cycle still happens; its word is stale.
                  if (imem_ready) begin
                     r_kill   <= 1'b1;
                     r_state  <= S_WAIT;
                     imem_req <= 1'b0;
                  end else begin
                     imem_addr <= w_target;
                  end
               end
               default: begin
                  r_state   <= S_REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= w_target;
               end
            endcase
         end else begin
            case (r_state)
               S_IDLE: begin
                  r_state   <= S_REQ;
                  imem_req  <= 1'b1;
                  imem_addr <= r_fetch_pc;
               end
               S_REQ: begin
                  if (imem_ready) begin
                     r_state  <= S_WAIT;
                     imem_req <= 1'b0;
                  end
               end
               S_WAIT: begin
                  if (imem_rvalid) begin
                     if (r_kill) begin
                        r_kill    <= 1'b0;
                        r_state   <= S_REQ;
                        imem_req  <= 1'b1;
                        imem_addr <= r_fetch_pc;
                     end else if (!instr_valid || !stall) begin
                        instr       <= imem_rdata;
                        pc          <= r_fetch_pc;
                        instr_valid <= 1'b1;
                        r_fetch_pc  <= w_next_pc;
                        r_state     <= S_REQ;
                        imem_req    <= 1'b1;
                        imem_addr   <= w_next_pc;
                     end else begin
                        r_skid_valid <= 1'b1;
                        r_skid_instr <= imem_rdata;
                        r_skid_pc    <= r_fetch_pc;
                        r_fetch_pc   <= w_next_pc;
                        r_state      <= S_HOLD;
                     end
                  end
               end
               S_HOLD: begin
                  if (!stall) begin
                     instr        <= r_skid_instr;
                     pc           <= r_skid_pc;
                     instr_valid  <= r_skid_valid;
                     r_skid_valid <= 1'b0;
                     r_state      <= S_REQ;
                     imem_req     <= 1'b1;
                     imem_addr    <= r_fetch_pc;
                  end
               end
               default: begin
                  r_state  <= S_IDLE;
                  imem_req <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// tb_instr_fetch_unit : directed bench with memory model and in-order scoreboard
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

   localparam logic [31:0] c_nop = 32'h00000013;

   logic        clk;
   logic        rst;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ready;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        branch_taken;
   logic [63:0] branch_target;
   logic        stall;
   logic        instr_valid;
   logic [31:0] instr;
   logic [63:0] pc;

   int total = 0;
   int bad   = 0;
   int pops  = 0;
   int mem_lat = 1;
   int r_cnt = 0;
   logic [63:0] r_raddr = '0;

   typedef struct packed {
      logic [63:0] pc;
      logic [31:0] ins;
   } ent_t;
   ent_t sb[$];

   instr_fetch_unit dut (
      .clk          (clk),
      .rst          (rst),
      .imem_req     (imem_req),
      .imem_addr    (imem_addr),
      .imem_ready   (imem_ready),
      .imem_rvalid  (imem_rvalid),
      .imem_rdata   (imem_rdata),
      .branch_taken (branch_taken),
      .branch_target(branch_target),
      .stall        (stall),
      .instr_valid  (instr_valid),
      .instr        (instr),
      .pc           (pc)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'h423AA503 ^ (a[31:0] * 32'h9E3779B9) ^ a[63:32];
   endfunction

   // Memory: rvalid mem_lat cycles after each handshake; ignores reset so a late reply can arrive.
   always @(posedge clk) begin
      if (imem_req && imem_ready) begin
         r_cnt   <= mem_lat;
         r_raddr <= imem_addr;
      end else if (r_cnt != 0) begin
         r_cnt <= r_cnt - 1;
      end
   end
   assign imem_rvalid = (r_cnt == 1);
   assign imem_rdata  = mem_word(r_raddr);

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Scoreboard: words pushed at handshake, popped when decode takes one, flushed on redirect/reset.
   always @(negedge clk) begin
      if (rst) begin
         sb.delete();
      end else begin
         if (instr_valid && !stall) begin
            if (sb.size() == 0) begin
               total++;
               bad++;
               $error("FAIL sb_empty observed_pc=%h expected=none", pc);
            end else begin
               ent_t e;
               e = sb.pop_front();
               chk("mon_pc", pc, e.pc);
               chk("mon_instr", {32'b0, instr}, {32'b0, e.ins});
               pops++;
            end
         end
         if (imem_req && imem_ready)
            sb.push_back('{pc: imem_addr, ins: mem_word(imem_addr)});
         if (branch_taken)
            sb.delete();
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b0; imem_ready = 1'b0; branch_taken = 1'b0;
      branch_target = '0; stall = 1'b0;
      #2 rst = 1'b1;
      tick(); tick();
      chk("rst_valid", {63'b0, instr_valid}, 64'd0);
      chk("rst_instr", {32'b0, instr}, {32'b0, c_nop});
      chk("rst_pc", pc, 64'd0);
      chk("rst_req", {63'b0, imem_req}, 64'd0);
      chk("rst_addr", imem_addr, 64'd0);

      // 1: first fetch
      rst = 1'b0;
      tick();
      chk("t1_req", {63'b0, imem_req}, 64'd1);
      chk("t1_addr", imem_addr, 64'd0);
      imem_ready = 1'b1;
      tick();
      chk("t1_wait_req", {63'b0, imem_req}, 64'd0);
      tick();
      chk("t1_instr", {32'b0, instr}, 64'h423AA503);
      chk("t1_pc", pc, 64'd0);
      chk("t1_valid", {63'b0, instr_valid}, 64'd1);
      chk("t1_next_addr", imem_addr, 64'd4);

      // 2: sequential stream, one word per two cycles
      for (int k = 1; k < 4; k++) begin
         tick();
         chk("t2_gap_valid", {63'b0, instr_valid}, 64'd0);
         tick();
         chk("t2_pc", pc, 64'(4 * k));
         chk("t2_instr", {32'b0, instr}, {32'b0, mem_word(64'(4 * k))});
         chk("t2_valid", {63'b0, instr_valid}, 64'd1);
      end

      // 3: stall five cycles, next word parks in skid
      stall = 1'b1;
      for (int k = 0; k < 5; k++) begin
         tick();
         chk("t3_frozen_pc", pc, 64'hC);
         chk("t3_frozen_valid", {63'b0, instr_valid}, 64'd1);
         if (k > 0) chk("t3_no_req", {63'b0, imem_req}, 64'd0);
      end
      stall = 1'b0;
      tick();
      chk("t3_skid_pc", pc, 64'h10);
      chk("t3_skid_instr", {32'b0, instr}, {32'b0, mem_word(64'h10)});
      chk("t3_after_addr", imem_addr, 64'h14);
      tick(); tick();
      chk("t3_next_pc", pc, 64'h14);

      // 4: redirect while waiting on a slow memory
      mem_lat = 3;
      tick();
      branch_taken = 1'b1; branch_target = 64'h1002;
      tick();
      branch_taken = 1'b0;
      chk("t4_valid", {63'b0, instr_valid}, 64'd0);
      chk("t4_instr", {32'b0, instr}, {32'b0, c_nop});
      tick(); tick();
      chk("t4_req", {63'b0, imem_req}, 64'd1);
      chk("t4_addr", imem_addr, 64'h1000);
      chk("t4_drop_valid", {63'b0, instr_valid}, 64'd0);
      mem_lat = 1;
      tick(); tick();
      chk("t4_pc", pc, 64'h1000);
      chk("t4_valid_new", {63'b0, instr_valid}, 64'd1);

      // 5: redirect + stall + handshake in the same cycle
      stall = 1'b1; branch_taken = 1'b1; branch_target = 64'h2000;
      tick();
      branch_taken = 1'b0; stall = 1'b0;
      chk("t5_flush_valid", {63'b0, instr_valid}, 64'd0);
      chk("t5_flush_instr", {32'b0, instr}, {32'b0, c_nop});
      tick();
      chk("t5_addr", imem_addr, 64'h2000);
      chk("t5_stale_valid", {63'b0, instr_valid}, 64'd0);
      tick(); tick();
      chk("t5_pc", pc, 64'h2000);
      chk("t5_instr", {32'b0, instr}, {32'b0, mem_word(64'h2000)});

      // 6: PC wrap, then reset in the middle of a wait
      imem_ready = 1'b0; branch_taken = 1'b1; branch_target = 64'hFFFF_FFFF_FFFF_FFFF;
      tick();
      branch_taken = 1'b0; imem_ready = 1'b1;
      chk("t6_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(); tick();
      chk("t6_pc_top", pc, 64'hFFFF_FFFF_FFFF_FFFC);
      chk("t6_wrap_addr", imem_addr, 64'd0);
      tick(); tick();
      chk("t6_pc_zero", pc, 64'd0);
      stall = 1'b1; mem_lat = 3;
      tick();
      chk("t6_wait_valid", {63'b0, instr_valid}, 64'd1);
      rst = 1'b1; imem_ready = 1'b0;
      #1;
      chk("t6_rst_valid", {63'b0, instr_valid}, 64'd0);
      chk("t6_rst_addr", imem_addr, 64'd0);
      chk("t6_rst_instr", {32'b0, instr}, {32'b0, c_nop});
      mem_lat = 1;
      tick();
      rst = 1'b0;
      tick(); tick();
      chk("t6_restart_req", {63'b0, imem_req}, 64'd1);
      chk("t6_restart_addr", imem_addr, 64'd0);
      chk("t6_late_ignored", {63'b0, instr_valid}, 64'd0);
      imem_ready = 1'b1; stall = 1'b0;
      tick(); tick();
      chk("t6_restart_pc", pc, 64'd0);
      chk("t6_restart_instr", {32'b0, instr}, 64'h423AA503);
      imem_ready = 1'b0;
      tick(); tick();
      chk("end_sb_empty", 64'(sb.size()), 64'd0);
      chk("end_pops", 64'(pops), 64'd9);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
